serial_responder: RTL

SERIAL_RESPONDER -- requirements
Module: serial_responder

---
 rtl/serial_responder_if.sv | 20 ++
 rtl/serial_responder.sv | 74 +++++++
 2 files changed

// File: rtl/serial_responder_if.sv
// serial_responder_if: strobe, parallel-load and serial-output signals of the responder.
interface serial_responder_if #(parameter int BITS = 8);
  logic                      latch_in;
  logic                      pulse_in;
  logic [BITS-1:0]           par_in;
  logic                      par_load;
  logic                      data_out;
  logic                      busy;
  logic                      frame_done;
  logic                      frame_abort;
  logic [$clog2(BITS+1)-1:0] bit_idx;
  modport slave (
    input  latch_in, pulse_in, par_in, par_load,
    output data_out, busy, frame_done, frame_abort, bit_idx
  );
  modport master (
    output latch_in, pulse_in, par_in, par_load,
    input  data_out, busy, frame_done, frame_abort, bit_idx
  );
endinterface

// File: rtl/serial_responder.sv
// serial_responder: shifts a held parallel word out MSB first, one bit per falling pulse
// strobe, framed by a latch strobe; both strobes are asynchronous and synchronized here.
module serial_responder #(
  parameter int BITS = 8
) (
  input logic             clk,
  input logic             rst,
  serial_responder_if.slave s
);
  localparam int IW = $clog2(BITS+1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_lsync, r_psync;
  logic [BITS-1:0] r_hold, r_shreg, w_src, w_shreg_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic            r_dout, r_busy, r_done, r_abort;
  logic            w_dout_nx, w_done_nx, w_abort_nx;
  logic            w_lrise, w_lfall, w_pfall, w_last, w_load, w_shift;
  // [0],[1] form the synchronizer, [2] is the history flop used for edge detection
  assign w_lrise = r_lsync[1] & ~r_lsync[2];
  assign w_lfall = ~r_lsync[1] & r_lsync[2];
  assign w_pfall = ~r_psync[1] & r_psync[2];
  assign w_last  = r_idx == IW'(BITS-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lsync <= '0;
      r_psync <= '0;
      r_hold  <= '0;
      r_shreg <= '0;
      r_idx   <= '0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lsync <= {r_lsync[1:0], s.latch_in};
      r_psync <= {r_psync[1:0], s.pulse_in};
      r_hold  <= s.par_load ? s.par_in : r_hold;
      r_shreg <= w_shreg_nx;
      r_idx   <= w_idx_nx;
      r_dout  <= w_dout_nx;
      r_busy  <= w_next != IDLE;
      r_done  <= w_done_nx;
      r_abort <= w_abort_nx;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_lrise ? LOAD : IDLE;
      LOAD:    w_next = w_lfall ? SHIFT : LOAD;
      SHIFT:   w_next = w_lrise ? LOAD : (w_pfall && !w_lfall && w_last) ? IDLE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  // latch edges win over a pulse edge arriving in the same cycle
  always_comb begin
    w_load     = (r_state == IDLE || r_state == SHIFT) && w_lrise;
    w_shift    = r_state == SHIFT && !w_lrise && !w_lfall && w_pfall;
    w_src      = s.par_load ? s.par_in : r_hold;
    w_shreg_nx = w_load ? w_src : w_shift ? {r_shreg[BITS-2:0], 1'b0} : r_shreg;
    w_idx_nx   = w_load ? '0 : w_shift ? r_idx + 1'b1 : r_idx;
    w_dout_nx  = w_load ? w_src[BITS-1] : w_shift ? (w_last ? 1'b0 : r_shreg[BITS-2]) : r_dout;
    w_done_nx  = w_shift && w_last;
    w_abort_nx = r_state == SHIFT && w_lrise;
  end
  assign s.data_out    = r_dout;
  assign s.busy        = r_busy;
  assign s.frame_done  = r_done;
  assign s.frame_abort = r_abort;
  assign s.bit_idx     = r_idx;
endmodule
